scie_fir_mc: RTL and testbench
==============================

// Module: scie_fir_mc
// PURPOSE
//  Multi-channel, parametrised FIR accelerator behind the SCIE custom-instruction port of the core.
//  Holds NCH independent channels, each with NTAPS coefficients, a sample delay line and a result register.
//  A single time-multiplexed MAC engine computes one output sample in NTAPS cycles.
//  io_busy lets the core stall; io_rd returns results and status.
// PARAMETERS
//  NCH    4   number of channels, 1..8; selected by insn[14:12]
//  NTAPS  5   taps per channel, >=1
//  DW     32  signed sample width; taken from rs1[DW-1:0]
//  CW     32  signed coefficient width; taken from rs1[CW-1:0]
//  XLEN   32  width of rs1, rs2 and rd
// PORTS
//  clock     in   1     core clock
//  reset     in   1     asynchronous, active-high reset
//  io_valid  in   1     instruction valid this cycle
//  io_insn   in   32    instruction word
//  io_rs1    in   XLEN  operand 1: coefficient or sample
//  io_rs2    in   XLEN  operand 2: coefficient index
//  io_rd     out  XLEN  registered read data
//  io_busy   out  1     MAC engine active; the core must not issue PUSH or SETC
// BEHAVIOUR
//  Decode (only when io_valid=1): opcode = insn[6:0]; ch = insn[14:12].
//   - An instruction with ch >= NCH is a no-op.
//  Opcodes:
//   - 0x0B SETC: coef[ch][rs2 mod NTAPS] <= rs1[CW-1:0].
//   - 0x2B PUSH: shift rs1 into the head of dline[ch]; the oldest sample drops out. Then start the MAC on ch.
//   - 0x5B READ: on the next edge, io_rd <= res[ch].
//     If insn[25]=1, io_rd <= {30'b0, ovr, busy} and ovr is cleared instead.
//  FSM states: IDLE, MAC, WB.
//   - IDLE -> MAC on an accepted PUSH; clear acc, k=0.
//   - MAC: acc += coef[ch][k] * dline[ch][k], with k=0 the newest sample; k++; -> WB after k=NTAPS-1.
//   - WB: res[ch] <= fmt(acc); -> IDLE.
//   - io_busy = (state != IDLE), registered. Result is visible to READ NTAPS+2 edges after the PUSH edge.
//  Arithmetic:
//   - Products are full precision, DW+CW bits, signed.
//   - acc is ACCW = DW+CW+clog2(NTAPS) bits, signed, and never overflows.
//   - fmt(): see CONFIGURATION.
//  Boundaries:
//   - PUSH or SETC while busy: dropped and sticky ovr set. State, coefficients and delay lines are unchanged.
//   - READ while busy: accepted; returns the stale res[ch].
//   - Status read in the same cycle as a new overrun: ovr stays 1 (set wins).
//   - NTAPS=1: MAC lasts 1 cycle.
//  Reset (asynchronous, any time including mid-MAC):
//   - state=IDLE; io_busy=0; io_rd=0; ovr=0.
//   - All coef, dline, res and acc = 0. An in-flight result is discarded.
// CONFIGURATION
//  SCIE_FIR_SAT_EN defined: fmt() saturates acc to the signed XLEN range [-2^(XLEN-1), 2^(XLEN-1)-1].
//  Undefined: fmt() = acc[XLEN-1:0] (two's-complement wrap).
// STRUCTURE
//  Package scie_fir_pkg:
//   - OPC_SETC, OPC_PUSH and OPC_READ constants; STATUS_BIT=25.
//   - fsm_t enum {IDLE, MAC, WB}.
//   - ACCW localparam function; sat_xlen() function.
//  Sub-module scie_fir_mac: one signed multiplier plus accumulator with clear and enable.
//  Tap and channel muxing stay in the top level.
// TESTING (NCH=4, NTAPS=5, DW=CW=32)
//  1. Filter results on ch0:
//     - SETC ch0 coef[0..4] = -36, -49, -51, -49, -11.
//     - PUSH -60 -> READ = 2160. PUSH -22 -> 3732. PUSH -71 -> 6694. PUSH -24 -> 8405. PUSH -18 -> 7183.
//     - Each READ is issued after io_busy falls.
//  2. Channel isolation, with the ch0 setup of test 1:
//     - PUSH 100 on ch1 (coefficients 0) -> ch1 READ = 0; ch0 READ still 7183.
//     - ch=5 instructions have no effect.
//  3. Busy timing and overrun:
//     - PUSH, then PUSH 7 on the next cycle -> io_busy high for NTAPS+1 cycles.
//     - The second push is dropped; status read = 0b10 then 0b00.
//     - Set-wins: issue a status READ and a dropped PUSH in the same cycle -> ovr stays 1.
//  4. Format, with coef[0]=0x7FFFFFFF, others 0, PUSH 0x7FFFFFFF:
//     - SCIE_FIR_SAT_EN defined -> READ 0x7FFFFFFF.
//     - SCIE_FIR_SAT_EN undefined -> READ 0x00000001.
//  5. Reset mid-MAC: assert reset 2 cycles after a PUSH.
//     - io_busy=0 and io_rd=0 immediately.
//     - Afterwards READ ch0 = 0, and a fresh PUSH -60 with no SETC gives 0.
//  6. Wrap-around of the tap index: SETC index 7 with NTAPS=5 writes coef[2].
//     - Verified by setting that coefficient to 3 and pushing 4 -> result 12 after two further pushes of 0.

Source files
------------

// File: rtl/scie_fir_pkg.sv
// Shared constants, FSM encoding and arithmetic helpers for the SCIE multi-channel FIR.
package scie_fir_pkg;

  localparam logic [6:0]  OPC_SETC   = 7'h0B;
  localparam logic [6:0]  OPC_PUSH   = 7'h2B;
  localparam logic [6:0]  OPC_READ   = 7'h5B;
  localparam int unsigned STATUS_BIT = 25;

  // Working width for saturation; comfortably wider than any supported accumulator.
  localparam int unsigned ACC_MAXW = 256;

  typedef enum logic [1:0] {IDLE, MAC, WB} fsm_t;

  function automatic int unsigned acc_width(input int unsigned dw, input int unsigned cw,
                                            input int unsigned ntaps);
    return dw + cw + unsigned'($clog2(ntaps));
  endfunction

  // Clamp a sign-extended accumulator to the signed xlen-bit range.
  function automatic logic [ACC_MAXW-1:0] sat_xlen(input logic [ACC_MAXW-1:0] a,
                                                   input int unsigned xlen);
    logic [ACC_MAXW-1:0] hi;
    logic [ACC_MAXW-1:0] lo;
    hi = (ACC_MAXW'(1) << (xlen - 1)) - ACC_MAXW'(1);
    lo = ~hi;
    if ($signed(a) > $signed(hi)) return hi;
    else if ($signed(a) < $signed(lo)) return lo;
    else return a;
  endfunction

endpackage

// File: rtl/scie_fir_mac.sv
// Single signed multiplier feeding an accumulator with synchronous clear and enable.
module scie_fir_mac #(
  parameter int unsigned AW   = 32,
  parameter int unsigned BW   = 32,
  parameter int unsigned ACCW = 67
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   en,
  input  logic signed [AW-1:0]   a,
  input  logic signed [BW-1:0]   b,
  output logic signed [ACCW-1:0] acc
);

  logic signed [AW+BW-1:0] prod;
  logic signed [ACCW-1:0]  acc_d;
  logic signed [ACCW-1:0]  acc_q;

  always_comb begin
    prod  = (AW+BW)'(a) * (AW+BW)'(b);
    acc_d = acc_q;
    if (clr)     acc_d = '0;
    else if (en) acc_d = acc_q + ACCW'(prod);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  assign acc = acc_q;

endmodule

// File: rtl/scie_fir_mc.sv
// Multi-channel FIR accelerator on the SCIE port; one shared MAC computes a sample in NTAPS cycles.
// Define SCIE_FIR_SAT_EN to saturate results to the signed XLEN range instead of wrapping.
module scie_fir_mc
  import scie_fir_pkg::*;
#(
  parameter int unsigned NCH   = 4,
  parameter int unsigned NTAPS = 5,
  parameter int unsigned DW    = 32,
  parameter int unsigned CW    = 32,
  parameter int unsigned XLEN  = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            io_valid,
  input  logic [31:0]     io_insn,
  input  logic [XLEN-1:0] io_rs1,
  input  logic [XLEN-1:0] io_rs2,
  output logic [XLEN-1:0] io_rd,
  output logic            io_busy
);

  localparam int unsigned ACCW = acc_width(DW, CW, NTAPS);
  localparam int unsigned TW   = (NTAPS > 1) ? $clog2(NTAPS) : 1;
  localparam int unsigned CHW  = (NCH > 1) ? $clog2(NCH) : 1;

  fsm_t            state_q, state_d;
  logic [TW-1:0]   k_q, k_d;
  logic [CHW-1:0]  ch_q, ch_d;
  logic            busy_q, busy_d;
  logic            ovr_q, ovr_d;
  logic [XLEN-1:0] rd_q, rd_d;

  logic signed [CW-1:0] coef_q  [NCH][NTAPS];
  logic signed [CW-1:0] coef_d  [NCH][NTAPS];
  logic signed [DW-1:0] dline_q [NCH][NTAPS];
  logic signed [DW-1:0] dline_d [NCH][NTAPS];
  logic [XLEN-1:0]      res_q   [NCH];
  logic [XLEN-1:0]      res_d   [NCH];

  logic [6:0]     opc;
  logic [2:0]     ch_raw;
  logic           ch_ok;
  logic [CHW-1:0] ch;
  logic [TW-1:0]  tap;
  logic           idle;
  logic           is_setc, is_push, is_read;
  logic           setc_ok, push_ok, drop, rd_res, rd_sts;

  logic                   mac_clr, mac_en;
  logic signed [ACCW-1:0] acc;
  logic [ACC_MAXW-1:0]    acc_ext;
  logic [ACC_MAXW-1:0]    fmt_full;
  logic [XLEN-1:0]        fmt_res;

  assign opc    = io_insn[6:0];
  assign ch_raw = io_insn[14:12];
  assign ch_ok  = 32'(ch_raw) < NCH;
  assign ch     = CHW'(ch_raw);
  assign tap    = TW'(io_rs2 % XLEN'(NTAPS));
  assign idle   = (state_q == IDLE);

  assign is_setc = io_valid && ch_ok && (opc == OPC_SETC);
  assign is_push = io_valid && ch_ok && (opc == OPC_PUSH);
  assign is_read = io_valid && ch_ok && (opc == OPC_READ);
  assign setc_ok = is_setc && idle;
  assign push_ok = is_push && idle;
  assign drop    = (is_setc || is_push) && !idle;
  assign rd_res  = is_read && !io_insn[STATUS_BIT];
  assign rd_sts  = is_read && io_insn[STATUS_BIT];

  scie_fir_mac #(
    .AW   (CW),
    .BW   (DW),
    .ACCW (ACCW)
  ) u_mac (
    .clk (clock),
    .rst (reset),
    .clr (mac_clr),
    .en  (mac_en),
    .a   (coef_q[ch_q][k_q]),
    .b   (dline_q[ch_q][k_q]),
    .acc (acc)
  );

  assign acc_ext = {{(ACC_MAXW-ACCW){acc[ACCW-1]}}, acc};
`ifdef SCIE_FIR_SAT_EN
  assign fmt_full = sat_xlen(acc_ext, XLEN);
`else
  assign fmt_full = acc_ext;
`endif
  assign fmt_res = fmt_full[XLEN-1:0];

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    ch_d    = ch_q;
    ovr_d   = ovr_q;
    rd_d    = rd_q;
    coef_d  = coef_q;
    dline_d = dline_q;
    res_d   = res_q;
    mac_clr = 1'b0;
    mac_en  = 1'b0;

    if (setc_ok) coef_d[ch][tap] = io_rs1[CW-1:0];

    if (push_ok) begin
      for (int unsigned i = NTAPS - 1; i > 0; i--) dline_d[ch][i] = dline_q[ch][i-1];
      dline_d[ch][0] = io_rs1[DW-1:0];
      ch_d    = ch;
      k_d     = '0;
      mac_clr = 1'b1;
      state_d = MAC;
    end

    if (rd_res) rd_d = res_q[ch];
    if (rd_sts) begin
      rd_d  = {{(XLEN-2){1'b0}}, ovr_q, busy_q};
      ovr_d = 1'b0;
    end
    // A drop in the same cycle as a status read must leave ovr set.
    if (drop) ovr_d = 1'b1;

    case (state_q)
      MAC: begin
        mac_en = 1'b1;
        if (k_q == TW'(NTAPS - 1)) state_d = WB;
        else                       k_d = k_q + 1'b1;
      end
      WB: begin
        res_d[ch_q] = fmt_res;
        state_d     = IDLE;
      end
      default: ;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      ch_q    <= '0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      ch_q    <= ch_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
      rd_q    <= rd_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      coef_q  <= '{default: '0};
      dline_q <= '{default: '0};
      res_q   <= '{default: '0};
    end else begin
      coef_q  <= coef_d;
      dline_q <= dline_d;
      res_q   <= res_d;
    end
  end

  assign io_rd   = rd_q;
  assign io_busy = busy_q;

  logic unused_bits;
  assign unused_bits = ^{io_insn[31:26], io_insn[24:15], io_insn[11:7], fmt_full[ACC_MAXW-1:XLEN]};

endmodule

// File: tb/tb_scie_fir_mc.sv
// Directed, table-driven bench for scie_fir_mc (NCH=4, NTAPS=5, DW=CW=XLEN=32).
module tb_scie_fir_mc;

  localparam logic [6:0] SETC = 7'h0B;
  localparam logic [6:0] PUSH = 7'h2B;
  localparam logic [6:0] READ = 7'h5B;

`ifdef SCIE_FIR_SAT_EN
  localparam logic [31:0] EXP_POS = 32'h7FFF_FFFF;
  localparam logic [31:0] EXP_NEG = 32'h8000_0000;
`else
  localparam logic [31:0] EXP_POS = 32'h0000_0001;
  localparam logic [31:0] EXP_NEG = 32'h0000_0002;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        io_valid;
  logic [31:0] io_insn;
  logic [31:0] io_rs1;
  logic [31:0] io_rs2;
  logic [31:0] io_rd;
  logic        io_busy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [2:0]  ch;
    logic [31:0] sample;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[8];

  scie_fir_mc #(
    .NCH   (4),
    .NTAPS (5),
    .DW    (32),
    .CW    (32),
    .XLEN  (32)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .io_valid (io_valid),
    .io_insn  (io_insn),
    .io_rs1   (io_rs1),
    .io_rs2   (io_rs2),
    .io_rd    (io_rd),
    .io_busy  (io_busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h (%0d) expected 0x%08h (%0d)", name, act, $signed(act), exp,
               $signed(exp));
    end
  endtask

  task automatic instr(input logic [6:0] op, input logic [2:0] ch, input logic sts,
                       input logic [31:0] rs1, input logic [31:0] rs2);
    io_insn  = {6'b0, sts, 10'b0, ch, 5'b0, op};
    io_rs1   = rs1;
    io_rs2   = rs2;
    io_valid = 1'b1;
    @(posedge clock);
    #1;
    io_valid = 1'b0;
    io_insn  = '0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (io_busy === 1'b1 && n < 50) begin
      @(posedge clock);
      #1;
      n++;
    end
    check({name, "_idle"}, {31'b0, io_busy}, 32'd0);
  endtask

  task automatic push_read(input string name, input logic [2:0] ch, input logic [31:0] s,
                           input logic [31:0] exp);
    instr(PUSH, ch, 1'b0, s, 32'd0);
    wait_idle(name);
    instr(READ, ch, 1'b0, 32'd0, 32'd0);
    check(name, io_rd, exp);
  endtask

  initial begin
    int bcnt;

    vecs[0] = '{3'd0, -32'sd60, 32'd2160};
    vecs[1] = '{3'd0, -32'sd22, 32'd3732};
    vecs[2] = '{3'd0, -32'sd71, 32'd6694};
    vecs[3] = '{3'd0, -32'sd24, 32'd8405};
    vecs[4] = '{3'd0, -32'sd18, 32'd7183};
    vecs[5] = '{3'd1, 32'd4,    32'd0};
    vecs[6] = '{3'd1, 32'd0,    32'd300};
    vecs[7] = '{3'd1, 32'd0,    32'd12};

    reset    = 1'b1;
    io_valid = 1'b0;
    io_insn  = '0;
    io_rs1   = '0;
    io_rs2   = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", {31'b0, io_busy}, 32'd0);
    check("rst_rd", io_rd, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Filter on ch0
    instr(SETC, 3'd0, 1'b0, -32'sd36, 32'd0);
    instr(SETC, 3'd0, 1'b0, -32'sd49, 32'd1);
    instr(SETC, 3'd0, 1'b0, -32'sd51, 32'd2);
    instr(SETC, 3'd0, 1'b0, -32'sd49, 32'd3);
    instr(SETC, 3'd0, 1'b0, -32'sd11, 32'd4);
    for (int i = 0; i < 5; i++) push_read($sformatf("fir_vec%0d", i), vecs[i].ch, vecs[i].sample,
                                          vecs[i].exp);

    // Channel isolation and out-of-range channel
    push_read("ch1_zero", 3'd1, 32'd100, 32'd0);
    instr(READ, 3'd0, 1'b0, 32'd0, 32'd0);
    check("ch0_keep", io_rd, 32'd7183);
    instr(SETC, 3'd5, 1'b0, 32'd99, 32'd0);
    instr(PUSH, 3'd5, 1'b0, 32'd99, 32'd0);
    check("ch5_nobusy", {31'b0, io_busy}, 32'd0);
    instr(READ, 3'd5, 1'b0, 32'd0, 32'd0);
    check("ch5_rd_hold", io_rd, 32'd7183);
    instr(READ, 3'd0, 1'b1, 32'd0, 32'd0);
    check("ch5_no_ovr", io_rd, 32'd0);

    // Busy window and overrun on ch2
    instr(SETC, 3'd2, 1'b0, 32'd1, 32'd0);
    instr(SETC, 3'd2, 1'b0, 32'd1000, 32'd1);
    instr(PUSH, 3'd2, 1'b0, 32'd5, 32'd0);
    bcnt = int'(io_busy);
    instr(PUSH, 3'd2, 1'b0, 32'd7, 32'd0);
    bcnt += int'(io_busy);
    for (int i = 0; i < 20 && io_busy === 1'b1; i++) begin
      @(posedge clock);
      #1;
      bcnt += int'(io_busy);
    end
    check("busy_cycles", bcnt, 32'd6);
    instr(READ, 3'd2, 1'b0, 32'd0, 32'd0);
    check("ovr_res", io_rd, 32'd5);
    instr(READ, 3'd2, 1'b1, 32'd0, 32'd0);
    check("status_ovr", io_rd, 32'd2);
    instr(READ, 3'd2, 1'b1, 32'd0, 32'd0);
    check("status_clr", io_rd, 32'd0);
    push_read("drop_dline", 3'd2, 32'd0, 32'd5000);

    // Status read while busy, then a fresh drop re-arms ovr; dropped SETC leaves coef alone
    instr(PUSH, 3'd2, 1'b0, 32'd0, 32'd0);
    instr(PUSH, 3'd2, 1'b0, 32'd9, 32'd0);
    instr(READ, 3'd2, 1'b1, 32'd0, 32'd0);
    check("status_busy", io_rd, 32'd3);
    instr(SETC, 3'd2, 1'b0, 32'd77, 32'd2);
    wait_idle("rearm");
    instr(READ, 3'd2, 1'b1, 32'd0, 32'd0);
    check("status_rearm", io_rd, 32'd2);
    instr(READ, 3'd2, 1'b0, 32'd0, 32'd0);
    check("drop_setc", io_rd, 32'd0);

    // Tap index wraps modulo NTAPS: index 7 lands on coef[2]
    instr(SETC, 3'd1, 1'b0, 32'd3, 32'd7);
    for (int i = 5; i < 8; i++) push_read($sformatf("wrap_vec%0d", i), vecs[i].ch, vecs[i].sample,
                                          vecs[i].exp);

    // Result formatting on ch3
    instr(SETC, 3'd3, 1'b0, 32'h7FFF_FFFF, 32'd0);
    push_read("fmt_pos", 3'd3, 32'h7FFF_FFFF, EXP_POS);
    push_read("fmt_neg", 3'd3, 32'hFFFF_FFFE, EXP_NEG);

    // Asynchronous reset in the middle of a MAC
    instr(PUSH, 3'd0, 1'b0, -32'sd60, 32'd0);
    instr(PUSH, 3'd0, 1'b0, 32'd1, 32'd0);
    @(posedge clock);
    #2;
    check("pre_rst_busy", {31'b0, io_busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_busy", {31'b0, io_busy}, 32'd0);
    check("mid_rst_rd", io_rd, 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    instr(READ, 3'd0, 1'b1, 32'd0, 32'd0);
    check("post_rst_status", io_rd, 32'd0);
    instr(READ, 3'd3, 1'b0, 32'd0, 32'd0);
    check("post_rst_ch3", io_rd, 32'd0);
    instr(READ, 3'd0, 1'b0, 32'd0, 32'd0);
    check("post_rst_ch0", io_rd, 32'd0);
    push_read("post_rst_push", 3'd0, -32'sd60, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
